// File: rtl/pio_irq_multi.sv
// pio_irq_multi: WIDTH-bit Avalon-MM input PIO with per-bit rise/fall edge capture, W1C clear and level irq.
// Optional per-bit debounce filter when PIO_IRQ_MULTI_DEBOUNCE_EN is defined.
module pio_irq_multi #(
    parameter int               WIDTH           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter logic [WIDTH-1:0] FALL_EN_RESET   = '1,
    parameter logic [WIDTH-1:0] RISE_EN_RESET   = '0,
    parameter int               DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] s, v, prev, edge_rise, edge_fall, irq_mask, edge_cap;
    logic [WIDTH-1:0] wd, edges, clr;
    logic [31:0]      rd;
    logic             wr;

    always_ff @(posedge clk or posedge reset)
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};

    assign s = sync_q[SYNC_STAGES-1];

`ifdef PIO_IRQ_MULTI_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [WIDTH-1:0][CW-1:0] cnt;
    logic [WIDTH-1:0]         filt;

    // cnt counts consecutive cycles of s disagreeing with filt; filt follows on the last one
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt  <= '0;
            filt <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++)
                if (s[i] == filt[i]) cnt[i] <= '0;
                else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    filt[i] <= s[i];
                    cnt[i]  <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
        end

    assign v = filt;
`else
    localparam int unused_debounce = DEBOUNCE_CYCLES;
    assign v = s;
`endif

    generate
        if (WIDTH < 32) begin : g_pad
            logic unused_wd;
            assign unused_wd = ^writedata[31:WIDTH];
        end
    endgenerate

    assign wr    = chipselect & ~write_n;
    assign wd    = writedata[WIDTH-1:0];
    assign edges = (v & ~prev & edge_rise) | (~v & prev & edge_fall);
    assign clr   = (wr && address == 3'd3) ? wd : '0;
    assign irq   = |(edge_cap & irq_mask);

    always_comb begin
        rd = '0;
        case (address)
            3'd0:    rd[WIDTH-1:0] = v;
            3'd1:    rd[WIDTH-1:0] = edge_rise;
            3'd2:    rd[WIDTH-1:0] = irq_mask;
            3'd3:    rd[WIDTH-1:0] = edge_cap;
            3'd4:    rd[WIDTH-1:0] = edge_fall;
            3'd5:    rd[WIDTH-1:0] = edge_cap & irq_mask;
            default: rd = '0;
        endcase
    end

    // a new edge beats a same-cycle W1C on the same bit
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            prev      <= '0;
            edge_rise <= RISE_EN_RESET;
            edge_fall <= FALL_EN_RESET;
            irq_mask  <= '0;
            edge_cap  <= '0;
            readdata  <= '0;
        end else begin
            prev     <= v;
            edge_cap <= edges | (edge_cap & ~clr);
            readdata <= rd;
            if (wr && address == 3'd1) edge_rise <= wd;
            if (wr && address == 3'd2) irq_mask  <= wd;
            if (wr && address == 3'd4) edge_fall <= wd;
        end
endmodule

// File: tb/tb_pio_irq_multi.sv
// tb_pio_irq_multi: scoreboard bench; a cycle-level model of the register-map rules predicts reads and irq,
// a negedge monitor compares whenever a read response or irq sample is due.
module tb_pio_irq_multi;
    localparam int W  = 8;
    localparam int SS = 2;
`ifdef PIO_IRQ_MULTI_DEBOUNCE_EN
    localparam int DB = 16;
`endif

    logic          clk = 0, reset = 1;
    logic [2:0]    address = 0;
    logic          chipselect = 0, write_n = 1;
    logic [31:0]   writedata = 0;
    logic [W-1:0]  in_port = 0;
    logic [31:0]   readdata;
    logic          irq;

    always #5 clk = ~clk;

    pio_irq_multi #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    int checks = 0, failures = 0;
    logic [31:0] rq[$];
    logic        iq[$];
    bit          rd_req = 0, rd_vld = 0;

    logic [W-1:0] hist [SS] = '{default: '0};
    logic [W-1:0] m_rise = '0, m_fall = '1, m_mask = '0, m_cap = '0, pv = '0;
`ifdef PIO_IRQ_MULTI_DEBOUNCE_EN
    logic [W-1:0] f = '0;
    int           cnt [W] = '{default: 0};
`endif

    function automatic logic [31:0] regval(input logic [2:0] a, input logic [W-1:0] data);
        case (a)
            3'd0: return 32'(data);
            3'd1: return 32'(m_rise);
            3'd2: return 32'(m_mask);
            3'd3: return 32'(m_cap);
            3'd4: return 32'(m_fall);
            3'd5: return 32'(m_cap & m_mask);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [W-1:0] s, v, e, clr;
        bit wr;
        if (reset) begin
            hist = '{default: '0};
            m_rise = '0; m_fall = '1; m_mask = '0; m_cap = '0; pv = '0;
`ifdef PIO_IRQ_MULTI_DEBOUNCE_EN
            f = '0; cnt = '{default: 0};
`endif
            rq.delete(); iq.delete(); rd_vld = 0;
            return;
        end
        s = hist[SS-1];
`ifdef PIO_IRQ_MULTI_DEBOUNCE_EN
        v = f;
`else
        v = s;
`endif
        if (rd_req) rq.push_back(regval(address, v));
        rd_vld = rd_req;
        wr  = chipselect && !write_n;
        e   = (v & ~pv & m_rise) | (~v & pv & m_fall);
        clr = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
        m_cap = e | (m_cap & ~clr);
        if (wr && address == 3'd1) m_rise = writedata[W-1:0];
        if (wr && address == 3'd2) m_mask = writedata[W-1:0];
        if (wr && address == 3'd4) m_fall = writedata[W-1:0];
        pv = v;
`ifdef PIO_IRQ_MULTI_DEBOUNCE_EN
        for (int i = 0; i < W; i++)
            if (s[i] != f[i]) begin
                cnt[i]++;
                if (cnt[i] == DB) begin f[i] = s[i]; cnt[i] = 0; end
            end else cnt[i] = 0;
`endif
        for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = in_port;
        iq.push_back(|(m_cap & m_mask));
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    initial forever begin
        logic        ei;
        logic [31:0] er;
        @(negedge clk);
        if (!reset) begin
            if (iq.size() != 0) begin
                ei = iq.pop_front();
                checks++;
                if (irq !== ei) begin
                    failures++;
                    $display("FAIL irq t=%0t got=%b exp=%b", $time, irq, ei);
                end
            end
            if (rd_vld) begin
                checks++;
                if (rq.size() == 0) begin
                    failures++;
                    $display("FAIL rd_underflow t=%0t got=%h exp=none", $time, readdata);
                end else begin
                    er = rq.pop_front();
                    if (readdata !== er) begin
                        failures++;
                        $display("FAIL readdata t=%0t got=%h exp=%h", $time, readdata, er);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1; write_n = 0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 0; write_n = 1;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a; rd_req = 1;
        @(negedge clk);
        rd_req = 0;
    endtask

    task automatic rd_all();
        for (int a = 0; a < 8; a++) rd(3'(a));
    endtask

    task automatic pulse_reset();
        #1 reset = 1;
        @(negedge clk);
        #1 reset = 0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 reset = 0;
        @(negedge clk);
        rd_all();
        // falling edge with default config, then W1C
        wr(2, 1); in_port = 8'h01; tick(SS + 3);
        in_port = 8'h00; tick(SS + 2);
        rd(3); rd(5); wr(3, 1); rd(3);
        // rising and both edges on bits 3:2
        wr(1, 8'h0C); wr(4, 8'h08); wr(2, 8'h0C);
        in_port = 8'h0C; tick(SS + 2); rd(3); rd(5);
        in_port = 8'h00; tick(SS + 2); rd(3); rd(5);
        wr(3, 8'hFF);
        // partial W1C, then edge/clear collision on bit 7
        wr(4, 8'hFF); in_port = 8'hF0; tick(SS + 3);
        in_port = 8'h00; tick(SS + 2);
        rd(3); wr(3, 8'h30); rd(3);
        in_port = 8'h80; tick(SS + 3);
        in_port = 8'h00; tick(SS);
        wr(3, 8'h80); rd(3);
        // mask only gates irq
        wr(2, 0); wr(3, 8'hFF);
        in_port = 8'h20; tick(SS + 3);
        in_port = 8'h00; tick(SS + 2);
        rd(3); wr(2, 8'h20); rd(5); rd(2);
        // reset mid-operation with an input held high through reset
        in_port = 8'h11; tick(SS + 1);
        pulse_reset();
        tick(SS + 3); rd_all();
        in_port = 8'h00; tick(SS + 2); rd(3);
`ifdef PIO_IRQ_MULTI_DEBOUNCE_EN
        wr(1, 8'h01); wr(2, 8'h01); wr(3, 8'hFF);
        in_port = 8'h01; tick(DB + SS + 4); rd(0); wr(3, 8'hFF); rd(3);
        in_port = 8'h00; tick(10); in_port = 8'h01; tick(DB + SS + 4); rd(0); rd(3);
        in_port = 8'h00; tick(20); rd(0); rd(3);
        in_port = 8'h01; tick(SS + 8);
        pulse_reset();
        rd(0); tick(DB + SS + 4); rd(0); rd(3);
`endif
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 4))
                0: begin in_port = in_port ^ W'($urandom); tick(1); end
                1: wr(3'($urandom_range(0, 7)), $urandom);
                2: wr(3, $urandom);
                3: rd(3'($urandom_range(0, 7)));
                default: tick($urandom_range(1, 4));
            endcase
        end
        rd_all();
        tick(3);
        checks++;
        if (rq.size() != 0) begin
            failures++;
            $display("FAIL rd_leftover got=%0d exp=0", rq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
